// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline registers: FSM encoding, width defaults, r0 constant.
package mips_pkg;

    localparam int DB_DEF = 32;
    localparam int RB_DEF = 5;
    localparam int unsigned REG_ZERO = 0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALT_WB = 2'd1,
        HALTED  = 2'd2
    } estado_t;

endpackage

// File: rtl/contador_retiro.sv
// Wrapping up-counter with increment enable and synchronous active-low clear.
// Latency: count visible one edge after inc; no backpressure.
module contador_retiro #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] cuenta
);

    logic [W-1:0] cuenta_q;

    always_ff @(posedge clk) begin
        if (!clr_n)
            cuenta_q <= '0;
        else if (inc)
            cuenta_q <= cuenta_q + W'(1);
    end

    assign cuenta = cuenta_q;

endmodule

// File: rtl/registro_mem_wb.sv
// MEM/WB pipeline register with stall/flush, sticky halt, optional retire counter (MEM_WB_RETIRE_CNT_EN).
// Latency: 1 cycle on load; Stall holds everything, Flush loads a bubble and wins over Stall.
module registro_mem_wb
    import mips_pkg::*;
#(
    parameter int DB = DB_DEF,
    parameter int RB = RB_DEF
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Stall,
    input  logic          Flush,
    input  logic [DB-1:0] ResultadoALU_in,
    input  logic [DB-1:0] DatoMem_in,
    input  logic [RB-1:0] RegDst_in,
    input  logic          RegWrite_in,
    input  logic          MemtoReg_in,
    input  logic          Valid_in,
    input  logic          Halt_in,
    output logic [DB-1:0] ResultadoALU_out,
    output logic [DB-1:0] DatoMem_out,
    output logic [RB-1:0] RegDst_out,
    output logic          RegWrite_out,
    output logic          MemtoReg_out,
    output logic          Valid_out,
    output logic          Halt_out
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [31:0]   RetiredCnt
`endif
);

    estado_t estado, estado_nxt;
    logic    do_load;
    logic    do_bubble;

    always_ff @(posedge Clk) begin
        if (!Reset_n)
            estado <= RUN;
        else
            estado <= estado_nxt;
    end

    always_comb begin
        estado_nxt = estado;
        case (estado)
            RUN:     if (!Flush && !Stall && Valid_in && Halt_in) estado_nxt = HALT_WB;
            HALT_WB: estado_nxt = HALTED;
            HALTED:  estado_nxt = HALTED;
            default: estado_nxt = RUN;
        endcase
    end

    // HALT_WB forces a bubble irrespective of Stall/Flush; HALTED freezes everything.
    always_comb begin
        do_load   = 1'b0;
        do_bubble = 1'b0;
        case (estado)
            RUN: begin
                do_bubble = Flush;
                do_load   = !Flush && !Stall;
            end
            HALT_WB: do_bubble = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ResultadoALU_out <= '0;
            DatoMem_out      <= '0;
            RegDst_out       <= '0;
            RegWrite_out     <= 1'b0;
            MemtoReg_out     <= 1'b0;
            Valid_out        <= 1'b0;
            Halt_out         <= 1'b0;
        end else if (do_bubble) begin
            RegDst_out   <= '0;
            RegWrite_out <= 1'b0;
            MemtoReg_out <= 1'b0;
            Valid_out    <= 1'b0;
            Halt_out     <= (estado == HALT_WB);
        end else if (do_load) begin
            ResultadoALU_out <= ResultadoALU_in;
            DatoMem_out      <= DatoMem_in;
            RegDst_out       <= RegDst_in;
            RegWrite_out     <= RegWrite_in && Valid_in && (RegDst_in != RB'(REG_ZERO));
            MemtoReg_out     <= MemtoReg_in && Valid_in;
            Valid_out        <= Valid_in;
            Halt_out         <= Halt_in && Valid_in;
        end
    end

`ifdef MEM_WB_RETIRE_CNT_EN
    logic retire_inc;
    assign retire_inc = do_load && Valid_in;

    contador_retiro #(.W(32)) u_cnt (
        .clk    (Clk),
        .clr_n  (Reset_n),
        .inc    (retire_inc),
        .cuenta (RetiredCnt)
    );
`endif

endmodule

// File: doc/registro_mem_wb.md
# registro_mem_wb

MEM/WB pipeline register: captures the memory-stage results and control of one instruction per cycle and presents them to the write-back stage. Its `ResultadoALU_out` and `DatoMem_out` feed the write-back 2:1 multiplexer directly, with `MemtoReg_out` driving that mux's select. It also provides stall and flush handling, a sticky halt state, and an optional retired-instruction counter.

## Interface
- `DB`, 32: data width of the ALU result and the memory read data.
- `RB`, 5: register-address width.
- `Clk` input 1: single clock; all state updates on the rising edge.
- `Reset_n` input 1: synchronous reset, active-low.
- `Stall` input 1: hold all registered outputs.
- `Flush` input 1: load a bubble.
- `ResultadoALU_in` input DB: ALU result from the MEM stage.
- `DatoMem_in` input DB: data-memory read data.
- `RegDst_in` input RB: destination register.
- `RegWrite_in` input 1: instruction writes the register file.
- `MemtoReg_in` input 1: write-back selects memory data (1) or ALU result (0).
- `Valid_in` input 1: MEM stage holds a real instruction.
- `Halt_in` input 1: instruction is HALT.
- `ResultadoALU_out`, `DatoMem_out` output DB: data operands for the write-back mux.
- `RegDst_out` output RB: registered destination register.
- `RegWrite_out` output 1: register-file write enable, gated as described under Operation.
- `MemtoReg_out` output 1: write-back mux select.
- `Valid_out` output 1: a real instruction is in WB.
- `Halt_out` output 1: sticky halt flag.
- `RetiredCnt` output 32: retired-instruction count; present only with the macro defined.

## Operation
- Update priority at each rising edge, highest first: reset, then halted hold, then flush, then stall, then load.
- **Reset** (`Reset_n`=0): all outputs go to 0, FSM goes to RUN, counter goes to 0.
- **Flush**: load a bubble. Valid, RegWrite, MemtoReg, Halt-capture and RegDst all go to 0; data outputs hold their previous values. Flush wins over Stall.
- **Stall** (no Flush): every register holds.
- **Load**: capture all inputs.
  - `RegWrite_out` = `RegWrite_in` & `Valid_in` & (`RegDst_in` != 0). Writes to r0 are never issued.
  - `MemtoReg_out` = `MemtoReg_in` & `Valid_in`.
- **FSM states: RUN, HALT_WB, HALTED.**
  - RUN → HALT_WB on a load with `Valid_in`=1 and `Halt_in`=1. The halt instruction is captured normally; `Halt_out` is asserted at the same edge.
  - HALT_WB → HALTED unconditionally on the next edge. At that edge a bubble is loaded regardless of inputs, Stall or Flush.
  - HALTED: remains there until reset. Outputs hold the bubble and `Halt_out` stays 1. Inputs are ignored.
- A reset asserted in any state, including mid-stall, returns the block to RUN with all outputs 0 on that edge.

## Timing
- Latency: exactly 1 cycle from input to output on a load.
- No combinational path from any input to any output.
- `Halt_out` rises on the same edge that makes the HALT instruction visible (`Valid_out`=1). `Valid_out` falls one edge later.
- Stall asserted for N cycles holds the outputs for N edges. The load occurs on the first edge with `Stall`=0.

## Configuration
- Macro: `MEM_WB_RETIRE_CNT_EN`.
- Defined:
  - `RetiredCnt` port exists.
  - Increments by 1 on every edge that loads `Valid_in`=1, including the HALT instruction. Never increments in HALT_WB or HALTED, or on stall, flush or reset edges.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: no port, no counter logic; all other behaviour is identical.

## Structure
- Shared package `mips_pkg`:
  - FSM state encoding: RUN=2'd0, HALT_WB=2'd1, HALTED=2'd2.
  - Defaults for `DB`/`RB`.
  - Register-zero constant `REG_ZERO`.
- One sub-module: `contador_retiro`, the wrapping counter with increment enable and synchronous active-low clear. It is instantiated only under the macro.

## Test plan
- **Reset:** hold `Reset_n`=0 with nonzero inputs for 2 cycles. Expected: all outputs 0, `RetiredCnt`=0.
- **Load and r0 gating:**
  - Load ALU=0x00000010, Mem=0xDEADBEEF, RegDst=5, RegWrite=1, MemtoReg=1, Valid=1. Expected next cycle: outputs match, `RegWrite_out`=1.
  - Repeat with RegDst=0. Expected: `RegWrite_out`=0.
- **Stall and flush:**
  - Stall for 3 cycles while inputs change. Expected: outputs unchanged for 3 cycles.
  - Assert Flush and Stall together. Expected: `Valid_out`=0 and `RegWrite_out`=0.
- **Halt:**
  - Load a HALT with Valid=1. Expected: next edge `Halt_out`=1 and `Valid_out`=1; the edge after, `Valid_out`=0.
  - Then drive 5 valid inputs. Expected: no output change and `RetiredCnt` frozen.
- **Counter wrap (macro on):** force the count to 0xFFFFFFFF, then load 1 valid instruction. Expected: `RetiredCnt`=0.
- **Reset from HALTED:** assert `Reset_n`=0 for 1 cycle, then load a valid instruction. Expected: `Halt_out`=0, state RUN, instruction passes with 1-cycle latency.
